// File: rtl/in_port.sv
// in_port: memory-mapped 8-bit input port with pin synchronizer, optional
// whole-byte debounce filter, sticky change flag and registered read path.
//
// Parameters:
//   SYNC_STAGES     synchronizer depth per pin (2..4)
//   DEBOUNCE_CYCLES stable cycles before a new value is accepted (2..255)
// Ports:
//   clk         core clock, rising edge
//   rst         synchronous reset, active-low
//   port[7:0]   asynchronous external pins
//   read_enable read strobe, one cycle per access
//   read_addr   0 = data register, 1 = status {7'b0, changed}
//   read_data   registered read result, holds when read_enable=0
//   changed     sticky flag, set when accepted data changes, cleared by a
//               data read (set wins on the same edge)
// Build option:
//   IN_PORT_DEBOUNCE_EN  defined: cand/cnt debounce filter present;
//                        undefined: data register follows the synchronizer.
module in_port #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port,
    input  logic       read_enable,
    input  logic       read_addr,
    output logic [7:0] read_data,
    output logic       changed
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
        $error("in_port: parameter out of legal range");
    end

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_out;
    logic [7:0] data_reg;
    logic [7:0] data_nxt;
    logic       load;
    logic       set_chg;
    logic       clr_chg;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
        end else begin
            sync_q[0] <= port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef IN_PORT_DEBOUNCE_EN
    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] cand;
    logic [7:0] cnt;

    // Any bit toggle restarts the count; the count saturates once the
    // candidate is accepted so a stable value is simply reloaded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cand <= 8'h00;
            cnt  <= 8'h00;
        end else if (sync_out != cand) begin
            cand <= sync_out;
            cnt  <= 8'h00;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign load     = (sync_out == cand) && (cnt == CNT_MAX);
    assign data_nxt = cand;
`else
    assign load     = 1'b1;
    assign data_nxt = sync_out;
`endif

    assign set_chg = load && (data_nxt != data_reg);
    assign clr_chg = read_enable && !read_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg <= 8'h00;
        end else if (load) begin
            data_reg <= data_nxt;
        end
    end

    // Set has priority over the clear of a concurrent data read, so a value
    // accepted on the read edge is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            changed <= 1'b0;
        end else if (set_chg) begin
            changed <= 1'b1;
        end else if (clr_chg) begin
            changed <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            read_data <= 8'h00;
        end else if (read_enable) begin
            read_data <= read_addr ? {7'b0, changed} : data_reg;
        end
    end

endmodule

// File: tb/tb_in_port.sv
// tb_in_port: directed self-checking bench for in_port.
// Works for both builds (IN_PORT_DEBOUNCE_EN defined or not).
module tb_in_port;

    localparam int S = 2;
    localparam int D = 16;
`ifdef IN_PORT_DEBOUNCE_EN
    localparam int LAT = S + D;
`else
    localparam int LAT = S;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] port = 8'h00;
    logic       read_enable = 1'b0;
    logic       read_addr = 1'b0;
    logic [7:0] read_data;
    logic       changed;

    int n_vec = 0;
    int n_err = 0;

    in_port #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .rst(rst),
        .port(port),
        .read_enable(read_enable),
        .read_addr(read_addr),
        .read_data(read_data),
        .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic addr);
        read_enable = 1'b1;
        read_addr = addr;
        step();
        read_enable = 1'b0;
        read_addr = 1'b0;
    endtask

    initial begin
        // reset with pins high
        rst = 1'b0;
        port = 8'hFF;
        repeat (3) step();
        chk("rst_read_data", read_data, 8'h00);
        chk("rst_changed", {7'b0, changed}, 8'h00);

        // release: first acceptance of FF sets changed
        rst = 1'b1;
        for (int i = 0; i < LAT + 10 && changed !== 1'b1; i++) step();
        chk("post_rst_changed", {7'b0, changed}, 8'h01);
        rd(1'b0);
        chk("post_rst_data", read_data, 8'hFF);
        chk("post_rst_clr", {7'b0, changed}, 8'h00);

        // settle to 00 and clear flag
        port = 8'h00;
        repeat (LAT + 4) step();
        rd(1'b0);
        chk("zero_data", read_data, 8'h00);
        chk("zero_clr", {7'b0, changed}, 8'h00);

`ifdef IN_PORT_DEBOUNCE_EN
        // short glitch rejected
        port = 8'h01;
        repeat (10) step();
        port = 8'h00;
        repeat (LAT + 10) step();
        chk("glitch_changed", {7'b0, changed}, 8'h00);
        rd(1'b0);
        chk("glitch_data", read_data, 8'h00);
`endif

        // exact acceptance latency 00 -> A5
        port = 8'hA5;
        repeat (LAT) step();
        chk("lat_early", {7'b0, changed}, 8'h00);
        step();
        chk("lat_exact", {7'b0, changed}, 8'h01);
        rd(1'b0);
        chk("lat_data", read_data, 8'hA5);

        // flag semantics, back-to-back reads
        port = 8'h3C;
        repeat (LAT + 3) step();
        read_enable = 1'b1;
        read_addr = 1'b1;
        step();
        chk("stat_read", read_data, 8'h01);
        chk("stat_keeps", {7'b0, changed}, 8'h01);
        read_addr = 1'b0;
        step();
        chk("data_read", read_data, 8'h3C);
        chk("data_clears", {7'b0, changed}, 8'h00);
        read_addr = 1'b1;
        step();
        chk("stat_after_clr", read_data, 8'h00);
        read_enable = 1'b0;
        read_addr = 1'b0;

        // set/clear collision on the acceptance edge
        port = 8'h5A;
        repeat (LAT) step();
        chk("coll_pre", {7'b0, changed}, 8'h00);
        rd(1'b0);
        chk("coll_old_data", read_data, 8'h3C);
        chk("coll_set_wins", {7'b0, changed}, 8'h01);
        rd(1'b0);
        chk("coll_new_data", read_data, 8'h5A);

        // read_data holds with read_enable low
        port = 8'hC3;
        repeat (LAT + 4) step();
        chk("hold_data", read_data, 8'h5A);
        chk("hold_flag", {7'b0, changed}, 8'h01);

        // reset mid-filter, then accept 77 after release
        port = 8'h77;
        repeat (LAT / 2 + 1) step();
        rst = 1'b0;
        step();
        chk("midrst_data", read_data, 8'h00);
        chk("midrst_flag", {7'b0, changed}, 8'h00);
        rst = 1'b1;
        repeat (LAT) step();
        chk("midrst_early", {7'b0, changed}, 8'h00);
        step();
        chk("midrst_exact", {7'b0, changed}, 8'h01);
        rd(1'b0);
        chk("midrst_value", read_data, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/in_port.md
# in_port

Memory-mapped 8-bit general-purpose input port, the read-side counterpart of the CPU's output port register. It samples eight asynchronous external pins through a synchronizer and an optional debounce filter, then holds the accepted value in a data register. It keeps a sticky "changed" flag and returns either the data or the status to the load path on a read strobe. It sits on the same peripheral bus as the output port and is clocked by the core clock.

## Interface
Parameters:
- SYNC_STAGES, 2: number of synchronizer flops per pin (legal range 2..4).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a new pin value is accepted (legal range 2..255). Used only when debounce is compiled in.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- port  input  8  external pins, asynchronous to clk.
- read_enable  input  1  read strobe from the load path, one cycle per access.
- read_addr  input  1  selects the register: 0 = data, 1 = status.
- read_data  output  8  registered read result.
- changed  output  1  sticky flag: the accepted data has changed since the last data read.

## Operation
- Synchronizer: a SYNC_STAGES-deep shift chain per bit. Its last stage is sync_out.
- Accept stage with debounce compiled in:
  - Internal candidate register cand (8 bits) and counter cnt (8 bits).
  - If sync_out != cand: cand <= sync_out, cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: data_reg <= cand, and cnt holds.
  - Otherwise: cnt <= cnt+1.
  - Filtering applies to the whole byte. Any bit toggle restarts the count.
- Accept stage without debounce: data_reg <= sync_out every cycle.
- Change flag:
  - It sets on any edge where data_reg is loaded with a value different from its current value.
  - It clears on a data read (read_enable=1, read_addr=0).
  - If set and clear happen on the same edge, set wins.
  - A status read does not clear it.
- Read path:
  - When read_enable=1, read_data <= data_reg (read_addr=0) or {7'b0, changed} (read_addr=1). Both values are taken before the edge.
  - When read_enable=0, read_data holds its value.
- Reset values (rst=0 at an edge): synchronizer chain, cand, cnt, data_reg, read_data, and changed are all 0.
  - A reset mid-debounce discards the count.
  - If pins are nonzero after reset, the first acceptance sets changed. This is intended: software reads and discards it.

## Timing
Let the pins settle to a new value before rising edge N, with SYNC_STAGES=S.
- sync_out shows the new value after edge N+S-1.
- Without debounce: data_reg and changed update at edge N+S (N+2 by default).
- With debounce: cand captures at edge N+S, and data_reg/changed update at edge N+S+DEBOUNCE_CYCLES (N+18 by default). This assumes the pins stay stable throughout.
- A glitch shorter than DEBOUNCE_CYCLES that returns to the accepted value never reaches data_reg.
- Read latency is 1 cycle: read_data is valid after the edge that samples read_enable.
- Back-to-back reads are allowed every cycle.

## Configuration
- IN_PORT_DEBOUNCE_EN:
  - Defined: the cand/cnt debounce filter is present, and DEBOUNCE_CYCLES is honoured.
  - Undefined: cand/cnt are not instantiated, data_reg follows sync_out directly, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset: hold rst=0 for 3 cycles with port=8'hFF → read_data=8'h00, changed=0. After release, data_reg=8'hFF at edge 2 (no debounce) or edge 18 (debounce), and changed=1.
- Latency: port 8'h00→8'hA5 before edge N, debounce on → data_reg=8'hA5 exactly at edge N+18, and not at N+17. With the macro off → exactly N+2.
- Glitch reject (debounce on): port 8'h00→8'h01 for 10 cycles then back to 8'h00 → data_reg stays 8'h00 and changed stays 0.
- Flag semantics:
  - After a change to 8'h3C, a status read returns 8'h01 and changed stays 1.
  - A data read then returns 8'h3C, and changed=0 on the next cycle.
- Set/clear collision: a data read on the same edge that accepts a new value 8'h5A → read_data is the old value, and changed=1 afterward.
- Reset mid-debounce: port changes to 8'h77, rst=0 at cycle N+10, then released → data_reg=0, cnt restarts, and 8'h77 is accepted 18 cycles after release.
